// File: rtl/ahb_apb_bridge_mp.sv
// AHB-Lite slave to APB3 master bridge with NUM_SLAVES equal address windows above BASE_ADDR.
// Adds byte strobes, decode-miss / PSLVERR / PREADY-timeout ERROR responses.
module ahb_apb_bridge_mp #(
   parameter int unsigned            DATA_WIDTH     = 32,
   parameter int unsigned            ADDR_WIDTH     = 32,
   parameter int unsigned            NUM_SLAVES     = 8,
   parameter logic [ADDR_WIDTH-1:0]  BASE_ADDR      = 32'h0300_0000,
   parameter int unsigned            SLOT_LOG2      = 8,
   parameter int unsigned            TIMEOUT_CYCLES = 255
) (
   input  logic                             hclk_i,
   input  logic                             hreset_i,
   input  logic                             hsel_i,
   input  logic [ADDR_WIDTH-1:0]            haddr_i,
   input  logic [1:0]                       htrans_i,
   input  logic                             hwrite_i,
   input  logic [2:0]                       hsize_i,
   input  logic [DATA_WIDTH-1:0]            hwdata_i,
   input  logic                             hready_i,
   output logic [DATA_WIDTH-1:0]            hrdata_o,
   output logic                             hreadyout_o,
   output logic                             hresp_o,
   output logic [NUM_SLAVES-1:0]            psel_o,
   output logic [ADDR_WIDTH-1:0]            paddr_o,
   output logic                             penable_o,
   output logic                             pwrite_o,
   output logic [DATA_WIDTH-1:0]            pwdata_o,
   output logic [DATA_WIDTH/8-1:0]          pstrb_o,
   input  logic [NUM_SLAVES*DATA_WIDTH-1:0] prdata_i,
   input  logic [NUM_SLAVES-1:0]            pready_i,
   input  logic [NUM_SLAVES-1:0]            pslverr_i
);

   typedef enum logic [2:0] {IDLE, SETUP, ACCESS, ERR1, ERR2} state_t;

   localparam logic [15:0] TO_LAST = 16'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

   state_t                  state_q, state_d;
   logic [ADDR_WIDTH-1:0]   paddr_q, paddr_d;
   logic                    pwrite_q, pwrite_d;
   logic [2:0]              hsize_q, hsize_d;
   logic [3:0]              idx_q, idx_d;
   logic [15:0]             timer_q, timer_d;

   logic [ADDR_WIDTH-1:0]   offset, idx_full;
   logic                    valid, miss, accept, done;
   logic                    sel_rdy, sel_err;
   logic [DATA_WIDTH-1:0]   sel_rdata;

   assign valid    = hsel_i & htrans_i[1] & hready_i;
   assign offset   = haddr_i - BASE_ADDR;
   assign idx_full = offset >> SLOT_LOG2;
   assign miss     = (haddr_i < BASE_ADDR) || (idx_full >= ADDR_WIDTH'(NUM_SLAVES));

   always_comb begin
      psel_o = '0;
      if (state_q == SETUP || state_q == ACCESS) begin
         for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
            psel_o[i] = (idx_q == 4'(i));
         end
      end
   end

   // Mux only the selected slave's response; others are ignored.
   always_comb begin
      sel_rdy   = 1'b0;
      sel_err   = 1'b0;
      sel_rdata = '0;
      for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
         if (psel_o[i]) begin
            sel_rdy   = sel_rdy | pready_i[i];
            sel_err   = sel_err | pslverr_i[i];
            sel_rdata = sel_rdata | prdata_i[i*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   assign done   = (state_q == ACCESS) && sel_rdy && !sel_err;
   assign accept = valid && (state_q == IDLE || state_q == ERR2 || done);

   always_comb begin
      state_d  = state_q;
      paddr_d  = paddr_q;
      pwrite_d = pwrite_q;
      hsize_d  = hsize_q;
      idx_d    = idx_q;
      timer_d  = timer_q;

      hreadyout_o = 1'b1;
      hresp_o     = 1'b0;
      penable_o   = 1'b0;
      hrdata_o    = '0;

      case (state_q)
         IDLE: begin
            state_d = IDLE;
         end
         SETUP: begin
            hreadyout_o = 1'b0;
            timer_d     = '0;
            state_d     = ACCESS;
         end
         ACCESS: begin
            penable_o   = 1'b1;
            hreadyout_o = done;
            if (done) begin
               state_d = IDLE;
               if (!pwrite_q) hrdata_o = sel_rdata;
            end else if (sel_rdy) begin
               state_d = ERR1;
            end else if (TIMEOUT_CYCLES != 0 && timer_q == TO_LAST) begin
               state_d = ERR1;
            end else if (TIMEOUT_CYCLES != 0) begin
               timer_d = timer_q + 16'd1;
            end
         end
         ERR1: begin
            hresp_o     = 1'b1;
            hreadyout_o = 1'b0;
            state_d     = ERR2;
         end
         ERR2: begin
            hresp_o = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      if (accept) begin
         paddr_d  = haddr_i;
         pwrite_d = hwrite_i;
         hsize_d  = hsize_i;
         idx_d    = idx_full[3:0];
         state_d  = miss ? ERR1 : SETUP;
      end
   end

   always_ff @(posedge hclk_i or negedge hreset_i) begin
      if (!hreset_i) begin
         state_q  <= IDLE;
         paddr_q  <= '0;
         pwrite_q <= 1'b0;
         hsize_q  <= '0;
         idx_q    <= '0;
         timer_q  <= '0;
      end else begin
         state_q  <= state_d;
         paddr_q  <= paddr_d;
         pwrite_q <= pwrite_d;
         hsize_q  <= hsize_d;
         idx_q    <= idx_d;
         timer_q  <= timer_d;
      end
   end

   assign paddr_o  = paddr_q;
   assign pwrite_o = pwrite_q;

   always_comb begin
      pwdata_o = '0;
      pstrb_o  = '0;
      if (pwrite_q && (state_q == SETUP || state_q == ACCESS)) begin
         pwdata_o = hwdata_i;
         case (hsize_q)
            3'd0:    pstrb_o = 4'b0001 << paddr_q[1:0];
            3'd1:    pstrb_o = 4'b0011 << {paddr_q[1], 1'b0};
            default: pstrb_o = 4'hF;
         endcase
      end
   end

endmodule

// File: tb/tb_ahb_apb_bridge_mp.sv
// Directed table-driven bench for ahb_apb_bridge_mp plus hand sequences for
// ERR2 acceptance, back-to-back transfers, hready_i qualification and mid-transfer reset.
module tb_ahb_apb_bridge_mp;

   logic          hclk_i = 1'b0;
   logic          hreset_i;
   logic          hsel_i;
   logic [31:0]   haddr_i;
   logic [1:0]    htrans_i;
   logic          hwrite_i;
   logic [2:0]    hsize_i;
   logic [31:0]   hwdata_i;
   logic          hready_i;
   logic [31:0]   hrdata_o;
   logic          hreadyout_o;
   logic          hresp_o;
   logic [7:0]    psel_o;
   logic [31:0]   paddr_o;
   logic          penable_o;
   logic          pwrite_o;
   logic [31:0]   pwdata_o;
   logic [3:0]    pstrb_o;
   logic [255:0]  prdata_i;
   logic [7:0]    pready_i;
   logic [7:0]    pslverr_i;

   int total = 0;
   int bad   = 0;

   ahb_apb_bridge_mp #(
      .DATA_WIDTH(32), .ADDR_WIDTH(32), .NUM_SLAVES(8),
      .BASE_ADDR(32'h0300_0000), .SLOT_LOG2(8), .TIMEOUT_CYCLES(4)
   ) dut (
      .hclk_i(hclk_i), .hreset_i(hreset_i), .hsel_i(hsel_i), .haddr_i(haddr_i),
      .htrans_i(htrans_i), .hwrite_i(hwrite_i), .hsize_i(hsize_i), .hwdata_i(hwdata_i),
      .hready_i(hready_i), .hrdata_o(hrdata_o), .hreadyout_o(hreadyout_o), .hresp_o(hresp_o),
      .psel_o(psel_o), .paddr_o(paddr_o), .penable_o(penable_o), .pwrite_o(pwrite_o),
      .pwdata_o(pwdata_o), .pstrb_o(pstrb_o), .prdata_i(prdata_i), .pready_i(pready_i),
      .pslverr_i(pslverr_i)
   );

   always #5 hclk_i = ~hclk_i;

   typedef struct {
      logic [31:0] addr;
      logic        wr;
      logic [2:0]  size;
      logic [31:0] wdata;
      int          slv;
      logic [31:0] rdata;
      int          waits;
      logic        err;
      logic [7:0]  exp_psel;
      logic [3:0]  exp_pstrb;
      logic [31:0] exp_hrdata;
      logic        exp_resp;
      int          exp_cyc;
      int          exp_pselcyc;
   } rec_t;

   rec_t vec[10];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic do_xfer(input rec_t r, input int n);
      int acc = 0, cyc = 0, psel_cyc = 0, resp_cyc = 0, leak = 0, multi = 0;
      logic [7:0]  psel_or = '0;
      logic [3:0]  strb = '0;
      logic [31:0] wd = '0;
      logic        fin = 1'b0;
      @(posedge hclk_i); #1;
      for (int i = 0; i < 8; i++) prdata_i[i*32 +: 32] = 32'hBAD0_0000 | 32'(i);
      prdata_i[r.slv*32 +: 32] = r.rdata;
      pready_i  = '0;
      pslverr_i = r.err ? (8'd1 << r.slv) : (8'd1 << ((r.slv + 1) % 8));
      hsel_i = 1'b1; htrans_i = 2'b10; haddr_i = r.addr; hwrite_i = r.wr; hsize_i = r.size;
      @(posedge hclk_i); #1;
      hsel_i = 1'b0; htrans_i = 2'b00; hwdata_i = r.wdata;
      while (!fin && cyc < 20) begin
         @(negedge hclk_i);
         if (penable_o) begin
            acc++;
            pready_i = (acc > r.waits) ? '1 : '0;
         end
         #1;
         cyc++;
         if (psel_o != 0) psel_cyc++;
         if ($countones(psel_o) > 1) multi++;
         psel_or |= psel_o;
         if (psel_o != 0 && !penable_o) strb = pstrb_o;
         if (penable_o && acc == 1) wd = pwdata_o;
         if (hresp_o) resp_cyc++;
         if (hreadyout_o) fin = 1'b1;
         else if (hrdata_o != 0) leak++;
      end
      chk($sformatf("v%0d_finished", n), 32'(fin), 32'd1);
      chk($sformatf("v%0d_cycles", n), 32'(cyc), 32'(r.exp_cyc));
      chk($sformatf("v%0d_psel", n), 32'(psel_or), 32'(r.exp_psel));
      chk($sformatf("v%0d_psel_cycles", n), 32'(psel_cyc), 32'(r.exp_pselcyc));
      chk($sformatf("v%0d_onehot_viol", n), 32'(multi), 32'd0);
      chk($sformatf("v%0d_pstrb", n), 32'(strb), 32'(r.exp_pstrb));
      chk($sformatf("v%0d_hrdata", n), hrdata_o, r.exp_hrdata);
      chk($sformatf("v%0d_hrdata_leak", n), 32'(leak), 32'd0);
      chk($sformatf("v%0d_hresp_final", n), 32'(hresp_o), 32'(r.exp_resp));
      chk($sformatf("v%0d_hresp_cycles", n), 32'(resp_cyc), r.exp_resp ? 32'd2 : 32'd0);
      if (r.exp_pselcyc > 0) begin
         chk($sformatf("v%0d_pwdata", n), wd, r.wr ? r.wdata : 32'd0);
         chk($sformatf("v%0d_paddr", n), paddr_o, r.addr);
         chk($sformatf("v%0d_pwrite", n), 32'(pwrite_o), 32'(r.wr));
      end
   endtask

   initial begin
      //        addr           wr    sz    wdata          slv rdata          wt  err   psel   strb     hrdata        rsp  cyc pc
      vec[0] = '{32'h0300_0104, 1'b0, 3'd2, 32'h0,         1, 32'hDEAD_BEEF, 0,  1'b0, 8'h02, 4'b0000, 32'hDEAD_BEEF, 1'b0, 2, 2};
      vec[1] = '{32'h0300_0203, 1'b1, 3'd0, 32'hAB00_0000, 2, 32'h0,         3,  1'b0, 8'h04, 4'b1000, 32'h0,         1'b0, 5, 5};
      vec[2] = '{32'h0300_0800, 1'b0, 3'd2, 32'h0,         0, 32'h0,         0,  1'b0, 8'h00, 4'b0000, 32'h0,         1'b1, 2, 0};
      vec[3] = '{32'h0300_0010, 1'b1, 3'd2, 32'hCAFE_F00D, 0, 32'h0,         0,  1'b1, 8'h01, 4'b1111, 32'h0,         1'b1, 4, 2};
      vec[4] = '{32'h0300_0300, 1'b0, 3'd2, 32'h0,         3, 32'h0,         99, 1'b0, 8'h08, 4'b0000, 32'h0,         1'b1, 7, 5};
      vec[5] = '{32'h0300_0702, 1'b1, 3'd1, 32'h1234_0000, 7, 32'h0,         0,  1'b0, 8'h80, 4'b1100, 32'h0,         1'b0, 2, 2};
      vec[6] = '{32'h0300_0501, 1'b1, 3'd0, 32'h0000_5A00, 5, 32'h0,         0,  1'b0, 8'h20, 4'b0010, 32'h0,         1'b0, 2, 2};
      vec[7] = '{32'h02FF_FFFC, 1'b0, 3'd2, 32'h0,         0, 32'h0,         0,  1'b0, 8'h00, 4'b0000, 32'h0,         1'b1, 2, 0};
      vec[8] = '{32'h0300_07FC, 1'b0, 3'd2, 32'h0,         7, 32'h55AA_1234, 1,  1'b0, 8'h80, 4'b0000, 32'h55AA_1234, 1'b0, 3, 3};
      vec[9] = '{32'h0300_0000, 1'b1, 3'd1, 32'h0000_BEEF, 0, 32'h0,         0,  1'b0, 8'h01, 4'b0011, 32'h0,         1'b0, 2, 2};

      hreset_i = 1'b0; hsel_i = 1'b0; haddr_i = '0; htrans_i = 2'b00; hwrite_i = 1'b0;
      hsize_i = 3'd0; hwdata_i = '0; hready_i = 1'b1; prdata_i = '0; pready_i = '0; pslverr_i = '0;
      repeat (2) @(posedge hclk_i);
      #1;
      chk("rst_hreadyout", 32'(hreadyout_o), 32'd1);
      chk("rst_hresp", 32'(hresp_o), 32'd0);
      chk("rst_hrdata", hrdata_o, 32'd0);
      chk("rst_psel", 32'(psel_o), 32'd0);
      chk("rst_penable", 32'(penable_o), 32'd0);
      chk("rst_paddr", paddr_o, 32'd0);
      chk("rst_pwrite", 32'(pwrite_o), 32'd0);
      chk("rst_pstrb_pwdata", {pstrb_o, pwdata_o[27:0]}, 32'd0);
      hreset_i = 1'b1;

      // hready_i low or IDLE htrans must not start a transfer
      @(posedge hclk_i); #1;
      hsel_i = 1'b1; htrans_i = 2'b10; haddr_i = 32'h0300_0104; hready_i = 1'b0;
      @(posedge hclk_i); #1;
      chk("noready_psel", 32'(psel_o), 32'd0);
      chk("noready_paddr", paddr_o, 32'd0);
      htrans_i = 2'b00; hready_i = 1'b1;
      @(posedge hclk_i); #1;
      chk("idletrans_hreadyout", 32'(hreadyout_o), 32'd1);
      chk("idletrans_paddr", paddr_o, 32'd0);
      hsel_i = 1'b0;

      for (int i = 0; i < 10; i++) do_xfer(vec[i], i);

      // New NONSEQ presented during ERR2 goes straight to SETUP
      do_xfer(vec[3], 10);
      hsel_i = 1'b1; htrans_i = 2'b10; haddr_i = 32'h0300_0100; hwrite_i = 1'b0; hsize_i = 3'd2;
      pready_i = '1;
      @(posedge hclk_i); #1;
      hsel_i = 1'b0; htrans_i = 2'b00;
      @(negedge hclk_i); #1;
      chk("err2acc_setup_psel", 32'(psel_o), 32'h02);
      chk("err2acc_setup_pen", 32'(penable_o), 32'd0);
      chk("err2acc_setup_hready", 32'(hreadyout_o), 32'd0);
      @(negedge hclk_i); #1;
      chk("err2acc_access_hready", 32'(hreadyout_o), 32'd1);
      chk("err2acc_hrdata", hrdata_o, 32'hBAD0_0001);
      chk("err2acc_hresp", 32'(hresp_o), 32'd0);

      // Back-to-back writes: slave 0 then slave 5 with no idle gap
      @(posedge hclk_i); #1;
      pslverr_i = '0; pready_i = '1;
      hsel_i = 1'b1; htrans_i = 2'b10; haddr_i = 32'h0300_0004; hwrite_i = 1'b1; hsize_i = 3'd2;
      @(posedge hclk_i); #1;
      haddr_i = 32'h0300_0508; hsize_i = 3'd0; hwdata_i = 32'h1111_1111;
      @(negedge hclk_i); #1;
      chk("b2b_first_setup", 32'(psel_o), 32'h01);
      @(negedge hclk_i); #1;
      chk("b2b_first_access", {30'd0, penable_o, hreadyout_o}, 32'd3);
      chk("b2b_first_pwdata", pwdata_o, 32'h1111_1111);
      @(posedge hclk_i); #1;
      hsel_i = 1'b0; htrans_i = 2'b00; hwdata_i = 32'h2222_2222;
      @(negedge hclk_i); #1;
      chk("b2b_second_setup_psel", 32'(psel_o), 32'h20);
      chk("b2b_second_setup_pen", 32'(penable_o), 32'd0);
      chk("b2b_second_pstrb", 32'(pstrb_o), 32'h1);
      chk("b2b_second_paddr", paddr_o, 32'h0300_0508);
      @(negedge hclk_i); #1;
      chk("b2b_second_access", {30'd0, penable_o, hreadyout_o}, 32'd3);
      chk("b2b_second_pwdata", pwdata_o, 32'h2222_2222);

      // Reset asserted mid-ACCESS returns everything to reset values at once
      @(posedge hclk_i); #1;
      pready_i = '0;
      hsel_i = 1'b1; htrans_i = 2'b10; haddr_i = 32'h0300_0300; hwrite_i = 1'b0; hsize_i = 3'd2;
      @(posedge hclk_i); #1;
      hsel_i = 1'b0; htrans_i = 2'b00;
      @(negedge hclk_i);
      @(negedge hclk_i); #1;
      chk("midrst_in_access", {30'd0, penable_o, hreadyout_o}, 32'd2);
      hreset_i = 1'b0;
      #1;
      chk("midrst_psel", 32'(psel_o), 32'd0);
      chk("midrst_penable", 32'(penable_o), 32'd0);
      chk("midrst_hreadyout", 32'(hreadyout_o), 32'd1);
      chk("midrst_paddr", paddr_o, 32'd0);
      @(posedge hclk_i); #1;
      hreset_i = 1'b1;
      @(posedge hclk_i); #1;
      chk("post_rst_idle", {29'd0, hresp_o, penable_o, hreadyout_o}, 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
